// File: rtl/pd_tx_controller.sv
`default_nettype none
// ============================================================================
// Module   : pd_tx_controller
// Purpose  : Arbitrates hash-result and heartbeat packets and sequences the
//            datapath strobes and tx valid/ready handshake for each packet.
// Revision : 1.0 - initial release
// ============================================================================
module pd_tx_controller #(
    parameter int         PKT_WORDS = 20,
    parameter logic [7:0] HASH_PID  = 8'h01,
    parameter logic [7:0] HB_PID    = 8'h02,
    parameter int         HB_PERIOD = 1000,
    parameter int         TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hash_req,
    output logic       hash_ack,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] PID,
    output logic       PID_en,
    output logic       transmit_empty_en,
    output logic       read_enable,
    output logic       data_sent,
    output logic       busy,
    output logic       pkt_type,
    output logic       abort_err
);

    localparam int c_idx_w = (PKT_WORDS > 2) ? $clog2(PKT_WORDS) : 1;
    localparam int c_to_w  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PKT_WORDS - 1);
    localparam logic [c_to_w-1:0]  c_to_lim   = c_to_w'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SEND  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic [c_to_w-1:0]  r_to_cnt;
    logic [c_to_w-1:0]  w_to_inc;
    logic               r_aborted;
    logic               r_abort_err;
    logic               r_type;
    logic [7:0]         r_pid;
    logic               w_hb_pend;
    logic               w_hb_done;
    logic               w_start_hash;
    logic               w_start_hb;
    logic               w_xfer;
    logic               w_timeout;

    assign w_to_inc  = (r_to_cnt == {c_to_w{1'b1}}) ? r_to_cnt : r_to_cnt + c_to_w'(1);
    assign w_xfer    = (r_state == S_SEND) && tx_ready;
    assign w_timeout = (TIMEOUT != 0) && (r_state == S_SEND) && !tx_ready
                       && (w_to_inc == c_to_lim);

    always_comb begin
        w_state_nxt  = r_state;
        w_start_hash = 1'b0;
        w_start_hb   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Hash wins any tie with a pending heartbeat
                if (hash_req) begin
                    w_start_hash = 1'b1;
                    w_state_nxt  = S_LOAD;
                end else if (w_hb_pend) begin
                    w_start_hb   = 1'b1;
                    w_state_nxt  = S_LOAD;
                end
            end
            S_LOAD: w_state_nxt = S_SEND;
            S_SEND: begin
                if ((w_xfer && (r_idx == c_last_idx)) || w_timeout) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_to_cnt    <= '0;
            r_aborted   <= 1'b0;
            r_abort_err <= 1'b0;
            r_type      <= 1'b0;
            r_pid       <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_hash) begin
                r_type <= 1'b0;
                r_pid  <= HASH_PID;
            end else if (w_start_hb) begin
                r_type <= 1'b1;
                r_pid  <= HB_PID;
            end
            if (r_state == S_LOAD) begin
                r_idx     <= '0;
                r_to_cnt  <= '0;
                r_aborted <= 1'b0;
            end else if (r_state == S_SEND) begin
                if (w_xfer) begin
                    r_idx    <= r_idx + c_idx_w'(1);
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= w_to_inc;
                end
            end
            if (w_timeout) begin
                r_aborted   <= 1'b1;
                r_abort_err <= 1'b1;
            end
        end
    end

    // An aborted packet neither acks the miner nor retires the heartbeat
    assign hash_ack          = (r_state == S_CLEAR) && !r_aborted && !r_type;
    assign w_hb_done         = (r_state == S_CLEAR) && !r_aborted && r_type;
    assign tx_valid          = (r_state == S_SEND);
    assign read_enable       = w_xfer;
    assign PID_en            = (r_state == S_LOAD);
    assign transmit_empty_en = (r_state == S_LOAD);
    assign data_sent         = (r_state == S_CLEAR);
    assign busy              = (r_state != S_IDLE);
    assign PID               = r_pid;
    assign pkt_type          = r_type;
    assign abort_err         = r_abort_err;

    generate
        if (HB_PERIOD > 0) begin : g_hb_timer
            localparam int c_hb_w = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
            localparam logic [c_hb_w-1:0] c_hb_last = c_hb_w'(HB_PERIOD - 1);

            logic [c_hb_w-1:0] r_hb_cnt;
            logic              r_hb_pend;
            logic              w_hb_wrap;

            assign w_hb_wrap = (r_hb_cnt == c_hb_last);

            // A wrap landing on the heartbeat's own completion keeps it pending
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hb_cnt  <= '0;
                    r_hb_pend <= 1'b0;
                end else begin
                    r_hb_cnt <= w_hb_wrap ? '0 : r_hb_cnt + c_hb_w'(1);
                    if (w_hb_wrap) begin
                        r_hb_pend <= 1'b1;
                    end else if (w_hb_done) begin
                        r_hb_pend <= 1'b0;
                    end
                end
            end

            assign w_hb_pend = r_hb_pend;
        end else begin : g_no_hb
            assign w_hb_pend = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pd_tx_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pd_tx_controller
// Purpose  : Self-checking bench: transaction-level reference model plus
//            directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pd_tx_controller;

    localparam int c_words = 20;
    localparam int c_hb    = 50;
    localparam int c_to    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, hash_req = 1'b0, tx_ready = 1'b0;
    logic       hash_ack, tx_valid, PID_en, transmit_empty_en, read_enable;
    logic       data_sent, busy, pkt_type, abort_err;
    logic [7:0] PID;

    logic       rst_b = 1'b1, hash_req_b = 1'b0, tx_ready_b = 1'b1;
    logic       hash_ack_b, tx_valid_b, PID_en_b, tee_b, re_b;
    logic       ds_b, busy_b, type_b, abort_b;
    logic [7:0] PID_b;

    pd_tx_controller #(
        .PKT_WORDS(c_words), .HASH_PID(8'h01), .HB_PID(8'h02),
        .HB_PERIOD(c_hb), .TIMEOUT(c_to)
    ) u_dut (
        .clk(clk), .rst(rst), .hash_req(hash_req), .hash_ack(hash_ack),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .PID(PID), .PID_en(PID_en),
        .transmit_empty_en(transmit_empty_en), .read_enable(read_enable),
        .data_sent(data_sent), .busy(busy), .pkt_type(pkt_type),
        .abort_err(abort_err)
    );

    pd_tx_controller #(
        .PKT_WORDS(20), .HASH_PID(8'h01), .HB_PID(8'h02),
        .HB_PERIOD(0), .TIMEOUT(255)
    ) u_dut_nohb (
        .clk(clk), .rst(rst_b), .hash_req(hash_req_b), .hash_ack(hash_ack_b),
        .tx_ready(tx_ready_b), .tx_valid(tx_valid_b), .PID(PID_b), .PID_en(PID_en_b),
        .transmit_empty_en(tee_b), .read_enable(re_b),
        .data_sent(ds_b), .busy(busy_b), .pkt_type(type_b),
        .abort_err(abort_b)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: packet-level bookkeeping advanced once per cycle
    bit         m_active, m_loading, m_sending, m_closing, m_aborted, m_kind;
    bit         m_hb_pend, m_abort_err, wrap, was_pend;
    int         m_words, m_stall, m_hb_t;
    logic [7:0] m_pid;
    bit         e_pid_en, e_valid, e_re, e_ds, e_ack;
    bit         mon_en = 1'b0;

    int         re_hash = 0, re_hb = 0, ack_cnt = 0;
    logic [8:0] pid_log[$];

    always @(negedge clk) begin
        e_pid_en = m_active && m_loading;
        e_valid  = m_active && m_sending;
        e_re     = e_valid && tx_ready;
        e_ds     = m_active && m_closing;
        e_ack    = e_ds && !m_aborted && !m_kind;
        if (mon_en) begin
            chk1("busy", busy, m_active);
            chk1("PID_en", PID_en, e_pid_en);
            chk1("transmit_empty_en", transmit_empty_en, e_pid_en);
            chk1("tx_valid", tx_valid, e_valid);
            chk1("read_enable", read_enable, e_re);
            chk1("data_sent", data_sent, e_ds);
            chk1("hash_ack", hash_ack, e_ack);
            chk1("abort_err", abort_err, m_abort_err);
            chk("PID", 32'(PID), 32'(m_pid));
            if (m_active) chk1("pkt_type", pkt_type, m_kind);
        end
        if (read_enable === 1'b1) begin
            if (pkt_type) re_hb++;
            else re_hash++;
        end
        if (hash_ack === 1'b1) ack_cnt++;
        if (PID_en === 1'b1) pid_log.push_back({pkt_type, PID});

        if (rst) begin
            m_active = 0; m_loading = 0; m_sending = 0; m_closing = 0;
            m_aborted = 0; m_kind = 0; m_hb_pend = 0; m_abort_err = 0;
            m_words = 0; m_stall = 0; m_hb_t = 0; m_pid = 8'h00;
        end else begin
            was_pend = m_hb_pend;
            wrap = 0;
            if (c_hb != 0) begin
                if (m_hb_t == c_hb - 1) begin
                    wrap = 1;
                    m_hb_t = 0;
                end else begin
                    m_hb_t++;
                end
            end
            if (m_closing && !m_aborted && m_kind) m_hb_pend = 0;
            if (wrap) m_hb_pend = 1;
            if (!m_active) begin
                if (hash_req) begin
                    m_active = 1; m_loading = 1; m_kind = 0; m_pid = 8'h01;
                end else if (was_pend) begin
                    m_active = 1; m_loading = 1; m_kind = 1; m_pid = 8'h02;
                end
            end else if (m_loading) begin
                m_loading = 0; m_sending = 1; m_words = 0; m_stall = 0;
            end else if (m_sending) begin
                if (tx_ready) begin
                    m_words++;
                    m_stall = 0;
                    if (m_words == c_words) begin
                        m_sending = 0; m_closing = 1; m_aborted = 0;
                    end
                end else begin
                    m_stall++;
                    if (c_to != 0 && m_stall == c_to) begin
                        m_sending = 0; m_closing = 1; m_aborted = 1; m_abort_err = 1;
                    end
                end
            end else if (m_closing) begin
                m_closing = 0; m_active = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; hash_req = 1'b0; tx_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int first_pid, pid_at, vf, vl, vcnt, recnt, ds_at, ack_at, thr, cnt_a, cnt_b;
    bit done, got_ack, busy0, busy23;
    logic [7:0] pid0;
    logic rs_busy, rs_valid, rs_pid_en, rs_ds, rs_abort, ab_ds, ab_ack, ab_err, pre_err, ab_busy;
    logic [7:0] rs_pid;

    initial begin
        // ---- reset, then a single hash packet with tx_ready held high
        do_reset();
        mon_en = 1'b1;
        hash_req = 1'b1; tx_ready = 1'b1;
        first_pid = -1; vf = -1; vl = -1; vcnt = 0; recnt = 0; ds_at = -1; ack_at = -1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (k == 0) begin busy0 = busy; pid0 = PID; end
            if (PID_en && first_pid < 0) begin first_pid = k; pid_at = int'(PID); end
            if (tx_valid) begin if (vf < 0) vf = k; vl = k; vcnt++; end
            if (read_enable) recnt++;
            if (data_sent) ds_at = k;
            if (hash_ack) ack_at = k;
            if (k == 23) busy23 = busy;
            tick();
            if (k == 22) hash_req = 1'b0;
        end
        chk1("reset_busy", busy0, 1'b0);
        chk("reset_pid", 32'(pid0), 32'h0);
        chk("first_pid_en_cycle", first_pid, 1);
        chk("first_pid_value", pid_at, 32'h01);
        chk("first_valid_cycle", vf, 2);
        chk("last_valid_cycle", vl, 21);
        chk("valid_cycles", vcnt, 20);
        chk("read_enable_pulses", recnt, 20);
        chk("data_sent_cycle", ds_at, 22);
        chk("hash_ack_cycle", ack_at, 22);
        chk1("busy_after_packet", busy23, 1'b0);

        // ---- backpressure 1,0,0,1
        do_reset();
        re_hash = 0; ack_cnt = 0; vf = -1; vl = -1; vcnt = 0; done = 0;
        hash_req = 1'b1; tx_ready = pat[0];
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (tx_valid && !pkt_type) begin if (vf < 0) vf = k; vl = k; vcnt++; end
            if (hash_ack) done = 1;
            tick();
            tx_ready = pat[(k + 1) % 4];
            if (done) hash_req = 1'b0;
        end
        chk1("bp_completed", done, 1'b1);
        chk("bp_read_enables", re_hash, 20);
        chk("bp_hash_acks", ack_cnt, 1);
        chk("bp_valid_contiguous", vcnt, vl - vf + 1);
        tx_ready = 1'b1;
        for (int k = 0; k < 60; k++) tick();

        // ---- hash request coinciding with heartbeat becoming pending
        do_reset();
        tx_ready = 1'b1;
        for (int k = 0; k < c_hb; k++) tick();
        hash_req = 1'b1;
        pid_log.delete();
        ack_cnt = 0;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            got_ack = hash_ack;
            tick();
            if (got_ack) hash_req = 1'b0;
        end
        chk("arb_packets", pid_log.size(), 2);
        if (pid_log.size() >= 2) begin
            chk("arb_first_is_hash", 32'(pid_log[0]), 32'h001);
            chk("arb_second_is_hb", 32'(pid_log[1]), 32'h102);
        end
        chk("arb_hash_acks", ack_cnt, 1);

        // ---- timeout abort and retry
        do_reset();
        hash_req = 1'b1; tx_ready = 1'b1;
        re_hash = 0; ack_cnt = 0; recnt = 0; ack_at = -1;
        for (int k = 0; k < 46; k++) begin
            @(negedge clk);
            if (k == 14) pre_err = abort_err;
            if (k == 15) begin ab_ds = data_sent; ab_ack = hash_ack; ab_err = abort_err; end
            if (k == 16) ab_busy = busy;
            if (k > 15 && read_enable) recnt++;
            if (hash_ack) ack_at = k;
            got_ack = hash_ack;
            tick();
            tx_ready = !((k + 1) >= 7 && (k + 1) <= 15);
            if (got_ack) hash_req = 1'b0;
        end
        chk1("to_err_before", pre_err, 1'b0);
        chk1("to_data_sent", ab_ds, 1'b1);
        chk1("to_no_ack", ab_ack, 1'b0);
        chk1("to_abort_err", ab_err, 1'b1);
        chk1("to_idle_after", ab_busy, 1'b0);
        chk("to_total_reads", re_hash, 25);
        chk("to_retry_reads", recnt, 20);
        chk("to_retry_ack_cycle", ack_at, 38);
        chk("to_acks", ack_cnt, 1);

        // ---- reset in the middle of a packet
        do_reset();
        hash_req = 1'b1; tx_ready = 1'b1;
        recnt = 0; ack_cnt = 0; ack_at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 13) begin
                rs_busy = busy; rs_valid = tx_valid; rs_pid_en = PID_en;
                rs_ds = data_sent; rs_abort = abort_err; rs_pid = PID;
            end
            if (k >= 13 && read_enable) recnt++;
            if (hash_ack) ack_at = k;
            got_ack = hash_ack;
            tick();
            rst = ((k + 1) == 12);
            if (got_ack) hash_req = 1'b0;
        end
        chk1("rst_busy", rs_busy, 1'b0);
        chk1("rst_tx_valid", rs_valid, 1'b0);
        chk1("rst_pid_en", rs_pid_en, 1'b0);
        chk1("rst_data_sent", rs_ds, 1'b0);
        chk1("rst_abort_err", rs_abort, 1'b0);
        chk("rst_pid", 32'(rs_pid), 32'h0);
        chk("rst_resend_reads", recnt, 20);
        chk("rst_resend_ack_cycle", ack_at, 35);
        chk("rst_acks", ack_cnt, 1);

        // ---- randomized traffic against the model
        do_reset();
        thr = 95;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            got_ack = hash_ack;
            tick();
            if (got_ack) hash_req = 1'b0;
            else if (!hash_req && $urandom_range(0, 19) == 0) hash_req = 1'b1;
            if (k % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0: thr = 95;
                    1: thr = 50;
                    default: thr = 3;
                endcase
            end
            tx_ready = ($urandom_range(0, 99) < thr);
            rst = ($urandom_range(0, 599) == 0);
        end
        rst = 1'b0; hash_req = 1'b0; tx_ready = 1'b1;
        for (int k = 0; k < 40; k++) tick();

        // ---- heartbeat disabled instance stays idle
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (PID_en_b !== 1'b0) cnt_a++;
            if (busy_b !== 1'b0) cnt_b++;
            tick();
        end
        chk("nohb_pid_en_pulses", cnt_a, 0);
        chk("nohb_busy_cycles", cnt_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
